// File: rtl/fifo_arb_pkg.sv
// Shared encodings and defaults for the two-requester FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SERVE0 = 2'd1,
      SERVE1 = 2'd2
   } state_t;

   localparam int DATA_W_DEF    = 8;
   localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between two requesters.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] data0,
   input  logic [DATA_W-1:0] data1,
   output logic              gnt0,
   output logic              gnt1,
   input  logic              fifo_full,
   output logic              fifo_w,
   output logic [DATA_W-1:0] fifo_data,
   output logic              busy
);

   localparam logic [2:0] LAST_BEAT = 3'(BURST_MAX - 1);

   state_t     state;
   state_t     nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;
   logic       last_served;
   logic       last_nxt;
   logic       beat;
   logic       cur_id;
   logic       cur_req;
   logic       oth_req;
   state_t     oth_state;

   // Both requesting: the one not served last wins.
   function automatic state_t pick(
      input logic r0,
      input logic r1,
      input logic last
   );
      state_t s;
      s = IDLE;
      unique case (1'b1)
         (r0 & r1):  s = last ? SERVE0 : SERVE1;
         (r0 & ~r1): s = SERVE0;
         (~r0 & r1): s = SERVE1;
         default:    s = IDLE;
      endcase
      return s;
   endfunction

   assign beat      = ((gnt0 & req0) | (gnt1 & req1)) & ~fifo_full;
   assign fifo_w    = beat;
   assign fifo_data = ({DATA_W{gnt0}} & data0) | ({DATA_W{gnt1}} & data1);

   assign cur_id    = (state == SERVE1);
   assign cur_req   = cur_id ? req1 : req0;
   assign oth_req   = cur_id ? req0 : req1;
   assign oth_state = cur_id ? SERVE0 : SERVE1;

   always_comb begin
      nxt      = state;
      cnt_nxt  = cnt;
      last_nxt = last_served;
      unique case (state)
         IDLE: begin
            nxt = pick(req0, req1, last_served);
         end
         SERVE0, SERVE1: begin
            if (!cur_req) begin
               nxt      = pick(req0, req1, last_served);
               last_nxt = cur_id;
            end else if (beat) begin
               if (cnt == LAST_BEAT) begin
                  cnt_nxt = '0;
                  if (oth_req) begin
                     nxt      = oth_state;
                     last_nxt = cur_id;
                  end
               end else begin
                  cnt_nxt = cnt + 3'd1;
               end
            end
         end
         default: begin
            nxt = IDLE;
         end
      endcase
      if (nxt != state) begin
         cnt_nxt = '0;
      end
   end

   // Grants and busy are registered copies of the next-state decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         last_served <= 1'b1;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= nxt;
         cnt         <= cnt_nxt;
         last_served <= last_nxt;
         gnt0        <= (nxt == SERVE0);
         gnt1        <= (nxt == SERVE1);
         busy        <= (nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, corner sequences, random vs model.
module tb_fifo_wr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0;
   logic       req1;
   logic [7:0] data0;
   logic [7:0] data1;
   logic       gnt0;
   logic       gnt1;
   logic       fifo_full;
   logic       fifo_w;
   logic [7:0] fifo_data;
   logic       busy;

   int n_tests;
   int n_fail;

   fifo_wr_arbiter #(.DATA_W(8), .BURST_MAX(4)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .req0      (req0),
      .req1      (req1),
      .data0     (data0),
      .data1     (data1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .fifo_full (fifo_full),
      .fifo_w    (fifo_w),
      .fifo_data (fifo_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rs;
      logic        r0;
      logic        r1;
      logic        f;
      logic [7:0]  d0;
      logic [7:0]  d1;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mk(
      input logic rs, input logic r0, input logic r1, input logic f,
      input logic [7:0] d0, input logic [7:0] d1,
      input logic g0, input logic g1, input logic w, input logic b,
      input logic [7:0] d
   );
      vec_t v;
      v.rs  = rs;
      v.r0  = r0;
      v.r1  = r1;
      v.f   = f;
      v.d0  = d0;
      v.d1  = d1;
      v.exp = {g0, g1, w, b, d};
      return v;
   endfunction

   function automatic logic [11:0] pk();
      return {gnt0, gnt1, fifo_w, busy, fifo_data};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req0      = 1'b0;
      req1      = 1'b0;
      fifo_full = 1'b0;
      data0     = '0;
      data1     = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Reference model: owner -1 = nobody, beats counted per turn.
   int m_own;
   int m_cnt;
   int m_last;

   task automatic model_step(input logic r0, input logic r1, input logic w);
      logic rq [2];
      int   i;
      int   j;
      rq[0] = r0;
      rq[1] = r1;
      if (m_own < 0) begin
         m_cnt = 0;
         if (r0 && r1) m_own = 1 - m_last;
         else if (r0)  m_own = 0;
         else if (r1)  m_own = 1;
      end else begin
         i = m_own;
         j = 1 - i;
         if (!rq[i]) begin
            m_last = i;
            m_cnt  = 0;
            m_own  = rq[j] ? j : -1;
         end else if (w) begin
            m_cnt++;
            if (m_cnt == 4) begin
               m_cnt = 0;
               if (rq[j]) begin
                  m_last = i;
                  m_own  = j;
               end
            end
         end
      end
   endtask

   initial begin
      int         beats;
      int         bad;
      int         n0;
      int         writes;
      int         wfull;
      int         s0;
      int         s1;
      int         nx [2];
      logic [7:0] v;
      logic [1:0] eg;
      logic [7:0] q [$];
      logic       ew;
      logic [7:0] ed;

      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      req0      = 1'b0;
      req1      = 1'b0;
      fifo_full = 1'b0;
      data0     = '0;
      data1     = '0;

      tbl[0]  = mk(0,1,1,0, 8'h10,8'h20, 0,0,0,0, 8'h00);
      tbl[1]  = mk(1,1,1,0, 8'h10,8'h20, 0,0,0,0, 8'h00);
      tbl[2]  = mk(1,1,1,0, 8'h11,8'h20, 1,0,1,1, 8'h11);
      tbl[3]  = mk(1,1,1,0, 8'h12,8'h20, 1,0,1,1, 8'h12);
      tbl[4]  = mk(1,1,1,1, 8'h13,8'h20, 1,0,0,1, 8'h13);
      tbl[5]  = mk(1,1,1,0, 8'h13,8'h20, 1,0,1,1, 8'h13);
      tbl[6]  = mk(1,1,1,0, 8'h14,8'h20, 1,0,1,1, 8'h14);
      tbl[7]  = mk(1,1,1,0, 8'h14,8'h21, 0,1,1,1, 8'h21);
      tbl[8]  = mk(1,1,0,0, 8'h14,8'h22, 0,1,0,1, 8'h22);
      tbl[9]  = mk(1,1,0,0, 8'h15,8'h22, 1,0,1,1, 8'h15);
      tbl[10] = mk(1,0,0,0, 8'h15,8'h22, 1,0,0,1, 8'h15);
      tbl[11] = mk(1,0,1,0, 8'h15,8'h23, 0,0,0,0, 8'h00);
      tbl[12] = mk(1,0,1,1, 8'h15,8'h23, 0,1,0,1, 8'h23);
      tbl[13] = mk(1,0,0,0, 8'h15,8'h23, 0,1,0,1, 8'h23);
      tbl[14] = mk(1,0,0,0, 8'h15,8'h23, 0,0,0,0, 8'h00);

      @(negedge clk);
      for (int k = 0; k < 15; k++) begin
         rst_n     = tbl[k].rs;
         req0      = tbl[k].r0;
         req1      = tbl[k].r1;
         fifo_full = tbl[k].f;
         data0     = tbl[k].d0;
         data1     = tbl[k].d1;
         #1;
         chk($sformatf("tbl%0d", k), 32'(pk()), 32'(tbl[k].exp));
         @(negedge clk);
      end

      // single requester, 10 cycles of req0
      do_reset();
      beats = 0;
      bad   = 0;
      v     = 8'h10;
      for (int c = 0; c < 11; c++) begin
         req0  = (c < 10);
         data0 = v;
         #1;
         if (c == 0) chk("s27_latency", 32'(gnt0), 32'd0);
         if (c == 1) chk("s27_grant", 32'(gnt0), 32'd1);
         if (fifo_w) begin
            if (fifo_data != 8'(8'h10 + beats)) bad++;
            beats++;
            v++;
         end
         @(negedge clk);
      end
      chk("s27_beats", 32'(beats), 32'd9);
      chk("s27_order", 32'(bad), 32'd0);

      // continuous contention
      do_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      for (int c = 0; c < 17; c++) begin
         #1;
         if (c == 0) eg = 2'b00;
         else eg = (((c - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
         chk($sformatf("s28_turn_c%0d", c), 32'({gnt0, gnt1, fifo_w}),
             32'({eg, c != 0}));
         @(negedge clk);
      end

      // full stall mid-burst
      do_reset();
      req0 = 1'b1;
      req1 = 1'b1;
      n0   = 0;
      for (int c = 0; c < 9; c++) begin
         fifo_full = (c >= 3 && c <= 5);
         #1;
         if (fifo_full) chk("s29_stall_w", 32'(fifo_w), 32'd0);
         if (fifo_w && gnt0) n0++;
         if (c == 7) chk("s29_still0", 32'({gnt0, gnt1}), 32'b10);
         if (c == 8) chk("s29_rotate", 32'({gnt0, gnt1}), 32'b01);
         @(negedge clk);
      end
      chk("s29_beats", 32'(n0), 32'd4);
      fifo_full = 1'b0;

      // early release by requester 1
      do_reset();
      req1 = 1'b1;
      @(negedge clk);
      req0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req1 = 1'b0;
      #1;
      chk("s30_drop", 32'({gnt0, gnt1, fifo_w}), 32'b010);
      @(negedge clk);
      #1;
      chk("s30_gnt0", 32'({gnt0, gnt1, fifo_w}), 32'b101);
      chk("s30_last", 32'(dut.last_served), 32'd1);
      @(negedge clk);

      // asynchronous reset in the middle of a requester-1 burst
      do_reset();
      req0  = 1'b1;
      req1  = 1'b1;
      data0 = 8'h5A;
      data1 = 8'hA5;
      for (int c = 0; c < 6; c++) @(negedge clk);
      #1;
      chk("s31_pre", 32'({gnt1, fifo_w}), 32'b11);
      #1;
      rst_n = 1'b0;
      #1;
      chk("s31_async", 32'(pk()), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("s31_idle", 32'({gnt0, gnt1, busy}), 32'd0);
      @(negedge clk);
      #1;
      chk("s31_first", 32'({gnt0, gnt1}), 32'b10);
      @(negedge clk);

      // both requesters streaming into a 16-entry FIFO
      do_reset();
      q.delete();
      s0     = 0;
      s1     = 0;
      writes = 0;
      wfull  = 0;
      req0   = 1'b1;
      req1   = 1'b1;
      for (int c = 0; c < 30; c++) begin
         fifo_full = (q.size() >= 16);
         data0     = {1'b0, 7'(s0)};
         data1     = {1'b1, 7'(s1)};
         #1;
         if (fifo_w) begin
            if (fifo_full) wfull++;
            else q.push_back(fifo_data);
            writes++;
            if (gnt0) s0++;
            else s1++;
         end
         @(negedge clk);
      end
      nx[0] = 0;
      nx[1] = 0;
      bad   = 0;
      foreach (q[k]) begin
         if (int'(q[k][6:0]) != nx[q[k][7]]) bad++;
         nx[q[k][7]]++;
      end
      if (nx[0] != s0 || nx[1] != s1) bad++;
      chk("s32_writes", 32'(writes), 32'd16);
      chk("s32_wfull", 32'(wfull), 32'd0);
      chk("s32_depth", 32'(q.size()), 32'd16);
      chk("s32_integrity", 32'(bad), 32'd0);

      // random traffic against the reference model
      do_reset();
      m_own  = -1;
      m_cnt  = 0;
      m_last = 1;
      for (int c = 0; c < 400; c++) begin
         req0      = ($urandom_range(0, 3) != 0);
         req1      = ($urandom_range(0, 3) != 0);
         fifo_full = ($urandom_range(0, 4) == 0);
         data0     = 8'($urandom);
         data1     = 8'($urandom);
         #1;
         ew = (m_own == 0 && req0 && !fifo_full) ||
              (m_own == 1 && req1 && !fifo_full);
         ed = (m_own == 0) ? data0 : (m_own == 1) ? data1 : 8'h00;
         chk($sformatf("rand_c%0d", c), 32'(pk()),
             32'({m_own == 0, m_own == 1, ew, m_own >= 0, ed}));
         model_step(req0, req1, ew);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of requester and FIFO write data.
REQ-002 The block SHALL have parameter BURST_MAX, default 4, legal range 1..8, meaning the maximum beats granted to one requester before rotation is offered.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (0 = reset).
REQ-005 The block SHALL have ports req0 and req1, input, 1 bit each, meaning the requester holds write intent and valid data.
REQ-006 The block SHALL have ports data0 and data1, input, DATA_W bits each, meaning the requester write data, stable while req is high.
REQ-007 The block SHALL have ports gnt0 and gnt1, output, 1 bit each, registered, meaning the requester currently owns the FIFO write port.
REQ-008 The block SHALL have port fifo_full, input, 1 bit, the full flag of the downstream 16-entry FIFO.
REQ-009 The block SHALL have port fifo_w, output, 1 bit, the FIFO write strobe.
REQ-010 The block SHALL have port fifo_data, output, DATA_W bits, the FIFO write data.
REQ-011 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, SERVE0 and SERVE1; gnt0 = (state==SERVE0) and gnt1 = (state==SERVE1), with at most one grant high.
REQ-013 A beat SHALL occur in a cycle when gnt_i & req_i & ~fifo_full is true; fifo_w SHALL be combinationally equal to this beat condition, and fifo_data SHALL be data_i of the granted requester (all zeros when no grant).
REQ-014 When fifo_full=1, no beat SHALL occur, the beat counter SHALL hold, and the state SHALL hold unless req_i drops.
REQ-015 From IDLE with only req_i high, the next state SHALL be SERVE_i, giving a latency of 1 cycle from req to gnt.
REQ-016 From IDLE with both requests high, the next state SHALL be SERVE of the requester that is not last_served; after reset, last_served SHALL equal 1, so requester 0 wins first.
REQ-017 In SERVE_i, each beat SHALL increment a 3-bit beat counter; the counter SHALL clear on every state change.
REQ-018 In SERVE_i, if req_i=0 the next state SHALL be SERVE_j when req_j=1, else IDLE.
REQ-019 In SERVE_i, when a beat brings the counter to BURST_MAX, the next state SHALL be SERVE_j if req_j=1; otherwise the state SHALL remain SERVE_i with the counter cleared.
REQ-020 Every exit from SERVE_i SHALL set last_served to i.
REQ-021 Rotation between SERVE0 and SERVE1 SHALL be direct, with no IDLE bubble; the new grant appears on the cycle after the last beat.
REQ-022 A requester SHALL never be granted while idle-requesting for more than BURST_MAX beats of the other requester plus 1 cycle, unless fifo_full stalls.

Reset
REQ-023 With reset=0, the block SHALL immediately set state=IDLE, gnt0=gnt1=0, beat counter=0, last_served=1 and busy=0; fifo_w and fifo_data SHALL read 0 without waiting for a clock edge.
REQ-024 Reset asserted mid-burst SHALL abort the burst with no further beat; after release, arbitration SHALL restart as in REQ-015/016.

Structure
REQ-025 A shared package fifo_arb_pkg SHALL hold the state encoding constants (IDLE=2'd0, SERVE0=2'd1, SERVE1=2'd2) and the default DATA_W and BURST_MAX values.
REQ-026 The design SHALL be a single flat module; the next-requester selection SHALL be one combinational function, not a sub-module, and the FIFO itself SHALL be instantiated by the parent.

Verification
REQ-027 The bench SHALL check single requester, BURST_MAX=4: req0=1 for 10 cycles -> gnt0 rises 1 cycle later and 9 beats occur with data0 values written in order.
REQ-028 The bench SHALL check contention: req0=req1=1 continuously -> gnt sequence 0,0,0,0,1,1,1,1,0...; exactly 4 beats per turn; no idle cycle between turns.
REQ-029 The bench SHALL check full stall: fifo_full=1 for 3 cycles mid-burst -> fifo_w=0 in those cycles, the counter holds, and the burst completes with 4 total beats after full drops.
REQ-030 The bench SHALL check early release: req1 drops after 2 beats while req0=1 -> gnt0 the next cycle, and last_served=1.
REQ-031 The bench SHALL check reset mid-burst: reset=0 asynchronously between edges -> gnt and fifo_w go 0 at once; after release with both requesting, requester 0 is granted first.
REQ-032 The bench SHALL check a 16-deep fill: both requesters stream into a 16-entry FIFO -> exactly 16 beats before full, no write while full, and no data lost or duplicated.
